// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and handshake levels.
package div_unit_pkg;

  localparam int REG_BUS_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on {partial remainder, quotient bits}.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0] work_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [2*DATA_W:0] work_o
);

  logic [2*DATA_W+1:0] shifted;
  logic [DATA_W+1:0]   diff;

  always_comb begin
    shifted = {work_i, 1'b0};
    // Upper slice is the shifted partial remainder; a clear sign bit means it covers the divisor.
    diff    = shifted[2*DATA_W+1:DATA_W] - {2'b00, divisor_i};
    work_o  = shifted[2*DATA_W:0];
    if (!diff[DATA_W+1]) begin
      work_o[2*DATA_W:DATA_W] = diff[DATA_W:0];
      work_o[0]               = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU; returns {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic              ready_o
);

  // Handshake: EX raises start_i and holds it until it has taken result_o; ready_o
  // rises with a valid result and stays high (result held) until start_i drops.
  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d, step_out;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   abs_op1, abs_op2, quo, rem;

  div_step #(.DATA_W(DATA_W)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    abs_op1   = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs_op2   = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    quo       = neg_quo_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    rem       = neg_rem_q ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];

    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          work_d    = {{(DATA_W+1){1'b0}}, abs_op1};
          divisor_d = abs_op2;
          neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];
          cnt_d     = '0;
          state_d   = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
        state_d  = DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          cnt_d   = '0;
          ready_d = DIV_RESULT_NOT_READY;
          state_d = DIV_FREE;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          result_d = {rem, quo};
          ready_d  = DIV_RESULT_READY;
          cnt_d    = '0;
          state_d  = DIV_END;
        end else begin
          work_d = step_out;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP || annul_i) begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          state_d  = DIV_FREE;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned divider in the EX stage, used for DIV/DIVU.
- Consumes the registered operands that the ID/EX forwarding register delivers on reg1_o (dividend) and reg2_o (divisor).
- Returns {remainder, quotient} for the HI/LO write path.
- Holds ready_o low while busy; the stall controller keeps EX stalled until ready_o rises.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset (`RstEnable = 1'b1); sampled on the rising edge of clk.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  32  dividend; sampled only on the accept edge.
- opdata2_i  input  32  divisor; sampled only on the accept edge.
- start_i  input  1  request (`DivStart); held high by EX until the result is consumed.
- annul_i  input  1  cancel; driven by exception or mispredict flush of the owning instruction.
- result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- ready_o  output  1  `DivResultReady when result_o is valid.

Behaviour:
- All outputs are registered. Reset applies on any edge with rst=1, in any state, including mid-division:
  - state = DivFree, counter = 0
  - ready_o = 0
  - result_o = 64'h0
- State machine, 2-bit; encodings come from the shared defines:
  - DivFree: on an edge with start_i=1 and annul_i=0, latch the operands.
    - Divisor == 0 -> DivByZero.
    - Otherwise -> DivOn with cnt = 0.
    - Signed mode: latch the absolute values and record the signs of the dividend and divisor.
  - DivByZero: next edge -> DivEnd with result_o = 64'h0.
  - DivOn: each edge performs one restoring shift-subtract step on a 65-bit working register and increments cnt.
    - Edge with cnt == 32: apply sign correction and load result_o.
      - Quotient is negated iff signed mode and the operand signs differ.
      - Remainder takes the sign of the dividend.
    - Same edge: set ready_o = 1 and go to DivEnd.
    - annul_i=1 on any DivOn edge -> DivFree, cnt = 0, ready_o stays 0, no result is loaded.
  - DivEnd: hold result_o and ready_o = 1 while start_i = 1.
    - Edge with start_i=0 -> DivFree, ready_o = 0, result_o = 0.
    - annul_i=1 in DivEnd -> DivFree, same as above.
- Latency:
  - Accept edge E0; iterations on E1..E32; ready_o is visible after E33.
  - Divide-by-zero: ready_o is visible after E1.
  - A new start is accepted only from DivFree. The minimum back-to-back gap is one cycle, with start_i low on the DivEnd exit edge.
- Edge cases:
  - start_i and annul_i together in DivFree: ignored, stay in DivFree.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wrap, no trap).
  - Operand changes after E0 are ignored.
- The counter saturates logic: cnt never exceeds 32; reaching DivOn with cnt > 32 is unreachable.

Decomposition:
- Add to the shared defines file:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11
  - DivResultReady / DivResultNotReady
  - DivStart / DivStop
- Reuse the existing `RegBus, `DoubleRegBus, `ZeroWord.
- Sub-module div_step (combinational, one shift-subtract iteration; 65-bit in, 65-bit out) is natural and lets the bench check single iterations.

Test Plan:
- DIVU, opdata1 = 100, opdata2 = 7, start held -> ready_o rises after E33, result_o = {32'd2, 32'd14}; drop start -> ready_o = 0 and result_o = 0 next edge.
- DIV, 0xFFFFFFF9 (-7) / 2 -> after E33, result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}; also 7 / -2 -> {32'h1, 32'hFFFFFFFD}.
- Divisor 0 (either mode), dividend 0x1234 -> ready_o after E1, result_o = 64'h0.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o = {32'h0, 32'h80000000} after E33.
- Start DIVU 1000 / 3, assert annul_i at E10 -> DivFree, ready_o never rises. Restart 9 / 4 on the next cycle -> {32'd1, 32'd2} after a full 33-edge latency.
- rst pulse at E20 of a division -> next edge ready_o = 0, result_o = 0, state DivFree; a subsequent start completes normally.
